// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: valid/ready result channel carrying {overflow, zero, carry, sum}
interface alu_result_fifo_if #(parameter int WIDTH = 4);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             zero;
  logic             overflow;
  modport master (output valid, s, c, zero, overflow, input ready);
  modport slave  (input valid, s, c, zero, overflow, output ready);
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: ALU result FIFO with sticky overflow, push counter; optional zero-flag check (ALU_ZERO_CHECK_EN)
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_fifo_if.slave         i_in,
  alu_result_fifo_if.master        o_out,
  input  logic                     i_clr_sticky,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_sticky_ovf,
  output logic [CNT_W-1:0]         o_result_cnt,
  output logic                     o_flag_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 3;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_sticky_ovf;
  logic [CNT_W-1:0] r_result_cnt;
  logic          w_push, w_pop;
  logic [EW-1:0] w_head;
  assign i_in.ready   = r_count != CW'(DEPTH);
  assign o_out.valid  = r_count != '0;
  assign w_push       = i_in.valid & i_in.ready;
  assign w_pop        = o_out.valid & o_out.ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign {o_out.overflow, o_out.zero, o_out.c, o_out.s} = w_head;
  assign o_count      = r_count;
  assign o_sticky_ovf = r_sticky_ovf;
  assign o_result_cnt = r_result_cnt;
  // entry storage: written at the write pointer on every accepted push
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (w_push)
      r_mem[r_wr_ptr] <= {i_in.overflow, i_in.zero, i_in.c, i_in.s};
  // pointers wrap naturally since DEPTH is a power of two; occupancy tracks push minus pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  // sticky overflow: a flagged push outranks a same-cycle clear; push counter wraps freely
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sticky_ovf <= 1'b0;
      r_result_cnt <= '0;
    end else begin
      r_sticky_ovf <= (w_push & i_in.overflow) | (r_sticky_ovf & ~i_clr_sticky);
      if (w_push) r_result_cnt <= r_result_cnt + 1'b1;
    end
`ifdef ALU_ZERO_CHECK_EN
  logic r_flag_err;
  // zero-flag consistency: latch any push whose zero bit disagrees with its sum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      r_flag_err <= 1'b0;
    else if (w_push && (i_in.zero != (i_in.s == '0)))
      r_flag_err <= 1'b1;
  assign o_flag_err = r_flag_err;
`else
  assign o_flag_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed stimulus with a queue scoreboard checked by an output monitor
module tb_alu_result_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_sticky = 1'b0;
  logic [2:0] count;
  logic       sticky_ovf;
  logic [7:0] result_cnt;
  logic       flag_err;
  int         errors = 0;
  int         checks = 0;
  int         pops = 0;
  logic [6:0] exp_q[$];
`ifdef ALU_ZERO_CHECK_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif
  alu_result_fifo_if #(.WIDTH(4)) up ();
  alu_result_fifo_if #(.WIDTH(4)) dn ();
  alu_result_fifo #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_in(up), .o_out(dn), .i_clr_sticky(clr_sticky),
    .o_count(count), .o_sticky_ovf(sticky_ovf), .o_result_cnt(result_cnt), .o_flag_err(flag_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [3:0] s, input logic c, input logic z,
                     input logic ov, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    up.valid = v; up.s = s; up.c = c; up.zero = z; up.overflow = ov;
    dn.ready = ordy; clr_sticky = clr;
    @(negedge clk);
    if (v && up.ready) exp_q.push_back({ov, z, c, s});
  endtask
  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  always @(negedge clk)
    if (rst_n && dn.valid && dn.ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_underflow: got %0h expected none", {dn.overflow, dn.zero, dn.c, dn.s});
      end else
        chk("pop_data", {25'd0, dn.overflow, dn.zero, dn.c, dn.s}, {25'd0, exp_q.pop_front()});
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    up.valid = 1'b0; up.s = '0; up.c = 1'b0; up.zero = 1'b0; up.overflow = 1'b0;
    dn.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", dn.valid, 0);
    chk("rst_in_ready", up.ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    chk("t1_out_valid", dn.valid, 0);
    chk("t1_in_ready", up.ready, 1);
    chk("t1_count", count, 0);
    chk("t1_sticky", sticky_ovf, 0);
    chk("t1_result_cnt", result_cnt, 0);
    chk("t1_out_s", dn.s, 0);
    chk("t1_flag_err", flag_err, 0);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t2_out_valid", dn.valid, 1);
    chk("t2_out_s", dn.s, 5);
    chk("t2_count", count, 1);
    chk("t2_result_cnt", result_cnt, 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t2_drained", count, 0);
    chk("t2_empty_valid", dn.valid, 0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", up.ready, 0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_held_ready", up.ready, 0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_pop_full_ready", up.ready, 0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_reenabled", up.ready, 1);
    chk("t3_count3", count, 3);
    repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t3_empty", count, 0);
    chk("t3_result_cnt", result_cnt, 6);
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t4_count", count, 2);
    chk("t4_head", dn.s, 8);
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t4_empty", count, 0);
    cyc(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t5_sticky_set", sticky_ovf, 1);
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    chk("t5_set_wins", sticky_ovf, 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t5_cleared", sticky_ovf, 0);
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t5_result_cnt", result_cnt, 11);
    chk("t6_flag_before", flag_err, 0);
    cyc(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t6_flag_err", flag_err, 32'(FE));
    repeat (3) idle();
    chk("t6_flag_persist", flag_err, 32'(FE));
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t6_result_cnt", result_cnt, 12);
    for (int i = 0; i < 244; i++) cyc(1'b1, 4'(i), i[0], (i % 16) == 0, i[1], 1'b1, 1'b0);
    idle();
    chk("wrap_result_cnt", result_cnt, 0);
    chk("wrap_count", count, 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("pop_total", pops, 256);
    chk("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("rst_pre_count", count, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_async_count", count, 0);
    chk("rst_async_valid", dn.valid, 0);
    chk("rst_async_ready", up.ready, 1);
    chk("rst_async_out_s", dn.s, 0);
    chk("rst_async_rcnt", result_cnt, 0);
    chk("rst_async_flag", flag_err, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    chk("rst_post_count", count, 0);
    chk("rst_post_valid", dn.valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
